can_frame_check: RTL and testbench
==================================

CAN_FRAME_CHECK -- requirements
Module: can_frame_check

Interface
REQ-001 SHALL have parameter FILT_ID, default 11'h000; acceptance ID.
REQ-002 SHALL have parameter FILT_MASK, default 11'h000; 1 = ID bit compared, 0 = don't care.
REQ-003 SHALL have port i_Clock, input, 1; sole clock, rising edge.
REQ-004 SHALL have port i_Rst_n, input, 1; asynchronous active-low reset.
REQ-005 SHALL have port i_Rx_DV, input, 1; one-cycle strobe: i_Rx_Frame valid.
REQ-006 SHALL have port i_Rx_Frame, input, [0:107]; frame from can_rx, bit 0 first on bus.
REQ-007 SHALL have port i_Frame_Ready, input, 1; consumer accepts output.
REQ-008 SHALL have port o_Frame_DV, output, 1; output fields valid.
REQ-009 SHALL have ports o_Id [10:0], o_Rtr 1, o_Dlc [3:0], o_Data [63:0]; decoded fields, MSB first as on bus.
REQ-010 SHALL have ports o_Crc_Err 1, o_Form_Err 1, o_Ack 1; status, qualified by o_Frame_DV.
REQ-011 SHALL have ports o_Busy 1, o_Overrun 1, o_Drop 1; level, pulse, pulse.

Function
REQ-012 SHALL use frame layout: SOF[0], ID[1:11], RTR[12], IDE[13], r0[14], DLC[15:18], DATA[19:82], CRC[83:97], CRC_DEL[98], ACK[99], ACK_DEL[100], EOF[101:107].
REQ-013 SHALL have FSM states IDLE, CRC, CHECK, VALID.
REQ-014 IDLE: i_Rx_DV=1 -> latch i_Rx_Frame into shift register, clear CRC, bit counter=0, go CRC.
REQ-015 CRC: one bit per clock over bits 0..82 (83 clocks): nxt = bit ^ crc[14]; crc = {crc[13:0],0} ^ (nxt ? 15'h4599 : 0); go CHECK after bit 82.
REQ-016 CHECK (1 clock): o_Crc_Err = (crc != frame[83:97]); o_Form_Err = SOF!=0 or CRC_DEL!=1 or ACK_DEL!=1 or any EOF bit !=1; o_Ack = ~frame[99]; register all fields.
REQ-017 o_Frame_DV SHALL rise after the 84th rising edge following the edge sampling i_Rx_DV.
REQ-018 Frames with o_Crc_Err=0, o_Form_Err=0 and ((ID ^ FILT_ID) & FILT_MASK) != 0 SHALL NOT be presented; pulse o_Drop one clock, return IDLE.
REQ-019 Erroneous frames SHALL be presented with error flags set, regardless of filter.
REQ-020 VALID: hold o_Frame_DV and fields stable until i_Frame_Ready=1 at a rising edge; then deassert o_Frame_DV next cycle, go IDLE.
REQ-021 i_Frame_Ready=1 with o_Frame_DV=0 SHALL have no effect.
REQ-022 i_Rx_DV=1 in CRC, CHECK or VALID SHALL be dropped and pulse o_Overrun one clock; current frame unaffected.
REQ-023 i_Rx_DV in the same cycle as the VALID->IDLE handshake SHALL be dropped (overrun).
REQ-024 o_Busy = 1 in every state except IDLE.
REQ-025 o_Dlc SHALL be reported raw (9..15 passed unchanged); DATA always 64 bits.

Reset
REQ-026 i_Rst_n=0 SHALL immediately force IDLE and all outputs 0, CRC and counter 0, mid-frame included; the interrupted frame is lost.
REQ-027 First i_Rx_DV SHALL be accepted on the first rising edge after i_Rst_n deasserts.

Configuration
REQ-028 With CAN_FILTER_EN defined, acceptance filtering per REQ-018 SHALL be compiled in.
REQ-029 Without CAN_FILTER_EN, every frame SHALL be presented, o_Drop tied 0, FILT_ID/FILT_MASK ignored.

Structure
REQ-030 Shared package can_pkg SHALL hold CAN_FRAME_W=108, field offset/width constants, CAN_CRC_POLY=15'h4599, and the FSM state enum.
REQ-031 CRC-15 step SHALL be one sub-module can_crc15 (bit in, enable, clear, crc out), reusable by can_tx.

Verification
REQ-032 Valid frame ID 0x014, DLC 4'h3, data 64'h5555_5555_5555_5555, correct CRC, ACK 0, mask 0 -> o_Frame_DV 84 clocks later, o_Id=0x014, o_Ack=1, both errors 0.
REQ-033 Same frame with bit 90 flipped -> o_Crc_Err=1, o_Form_Err=0, frame presented.
REQ-034 Same frame with bit 104 = 0 -> o_Form_Err=1.
REQ-035 CAN_FILTER_EN, FILT_ID=0x123, FILT_MASK=0x7FF, frame ID 0x014 -> o_Drop pulse, no o_Frame_DV; ID 0x123 -> presented.
REQ-036 Second i_Rx_DV at clock 40, then i_Frame_Ready held 0 for 10 clocks -> o_Overrun pulse, fields stable throughout, one frame out.
REQ-037 i_Rst_n low at clock 50 of CRC -> outputs 0 at once; fresh frame after release processes normally.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN constants: frame layout, CRC-15 polynomial, frame-check FSM states.
package can_pkg;

  localparam int CAN_FRAME_W  = 108;

  localparam int CAN_SOF_POS     = 0;
  localparam int CAN_ID_OFF      = 1;
  localparam int CAN_ID_W        = 11;
  localparam int CAN_RTR_POS     = 12;
  localparam int CAN_IDE_POS     = 13;
  localparam int CAN_R0_POS      = 14;
  localparam int CAN_DLC_OFF     = 15;
  localparam int CAN_DLC_W       = 4;
  localparam int CAN_DATA_OFF    = 19;
  localparam int CAN_DATA_W      = 64;
  localparam int CAN_CRC_OFF     = 83;
  localparam int CAN_CRC_W       = 15;
  localparam int CAN_CRC_DEL_POS = 98;
  localparam int CAN_ACK_POS     = 99;
  localparam int CAN_ACK_DEL_POS = 100;
  localparam int CAN_EOF_OFF     = 101;
  localparam int CAN_EOF_W       = 7;

  // Bits 0..82 (SOF through DATA) are covered by the CRC.
  localparam int CAN_CRC_BITS = CAN_CRC_OFF;

  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CRC   = 2'd1,
    ST_CHECK = 2'd2,
    ST_VALID = 2'd3
  } can_state_e;

  // One serial CRC-15 step for a single bus bit.
  function automatic logic [14:0] can_crc15_step(input logic [14:0] crc, input logic b);
    logic nxt;
    nxt = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (nxt ? CAN_CRC_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 accumulator, one bit per enabled clock; clear wins over enable.
module can_crc15
  import can_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Clear,
  input  logic        i_En,
  input  logic        i_Bit,
  output logic [14:0] o_Crc
);

  logic [14:0] crc_q;
  logic [14:0] crc_d;

  // Next CRC value: clear, advance by one bit, or hold.
  always_comb begin
    crc_d = crc_q;
    if (i_Clear)   crc_d = '0;
    else if (i_En) crc_d = can_crc15_step(crc_q, i_Bit);
  end

  // CRC register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign o_Crc = crc_q;

endmodule

// File: rtl/can_frame_check.sv
// CAN frame checker: recomputes CRC-15 over a received frame, checks fixed-form
// bits, decodes fields and presents them with a valid/ready handshake.
// Optional acceptance filtering is compiled in with CAN_FILTER_EN.
module can_frame_check
  import can_pkg::*;
#(
  parameter logic [10:0] FILT_ID   = 11'h000,
  parameter logic [10:0] FILT_MASK = 11'h000
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Rx_DV,
  input  logic [0:CAN_FRAME_W-1] i_Rx_Frame,
  input  logic                   i_Frame_Ready,
  output logic                   o_Frame_DV,
  output logic [10:0]            o_Id,
  output logic                   o_Rtr,
  output logic [3:0]             o_Dlc,
  output logic [63:0]            o_Data,
  output logic                   o_Crc_Err,
  output logic                   o_Form_Err,
  output logic                   o_Ack,
  output logic                   o_Busy,
  output logic                   o_Overrun,
  output logic                   o_Drop
);

  localparam logic [6:0] CNT_LAST = 7'(CAN_CRC_BITS - 1);

  can_state_e             state_q, state_d;
  logic [6:0]             cnt_q, cnt_d;
  logic [0:CAN_FRAME_W-1] frame_q, frame_d;
  logic                   frame_dv_q, frame_dv_d;
  logic [10:0]            id_q, id_d;
  logic                   rtr_q, rtr_d;
  logic [3:0]             dlc_q, dlc_d;
  logic [63:0]            data_q, data_d;
  logic                   crc_err_q, crc_err_d;
  logic                   form_err_q, form_err_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   drop_q, drop_d;

  logic                   crc_clear, crc_en, crc_bit;
  logic [14:0]            crc_val;
  logic [10:0]            id_f;
  logic                   crc_err_f, form_err_f, filt_hit;
  logic                   fields_unused;

  assign crc_clear = (state_q == ST_IDLE) && i_Rx_DV;
  assign crc_en    = (state_q == ST_CRC);
  assign crc_bit   = frame_q[cnt_q];

  can_crc15 u_crc (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Clear (crc_clear),
    .i_En    (crc_en),
    .i_Bit   (crc_bit),
    .o_Crc   (crc_val)
  );

  assign id_f       = frame_q[CAN_ID_OFF : CAN_ID_OFF+CAN_ID_W-1];
  assign crc_err_f  = (crc_val != frame_q[CAN_CRC_OFF : CAN_CRC_OFF+CAN_CRC_W-1]);
  assign form_err_f = frame_q[CAN_SOF_POS] | ~frame_q[CAN_CRC_DEL_POS] |
                      ~frame_q[CAN_ACK_DEL_POS] |
                      ~(&frame_q[CAN_EOF_OFF : CAN_EOF_OFF+CAN_EOF_W-1]);
  // IDE and r0 are carried in the frame but not reported.
  assign fields_unused = frame_q[CAN_IDE_POS] ^ frame_q[CAN_R0_POS];

`ifdef CAN_FILTER_EN
  // Only clean frames are filtered; erroneous frames are always reported.
  assign filt_hit = !crc_err_f && !form_err_f && (((id_f ^ FILT_ID) & FILT_MASK) != 11'h000);
`else
  logic filt_unused;
  assign filt_unused = ^(FILT_ID ^ FILT_MASK);
  assign filt_hit    = 1'b0;
`endif

  // Next-state and registered-output logic for the frame-check FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    frame_dv_d = frame_dv_q;
    id_d       = id_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    crc_err_d  = crc_err_q;
    form_err_d = form_err_q;
    ack_d      = ack_q;
    drop_d     = 1'b0;
    // Any strobe outside IDLE is lost, including one coincident with the handshake.
    overrun_d  = i_Rx_DV && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV) begin
          frame_d = i_Rx_Frame;
          cnt_d   = '0;
          state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_CHECK: begin
        id_d       = id_f;
        rtr_d      = frame_q[CAN_RTR_POS];
        dlc_d      = frame_q[CAN_DLC_OFF : CAN_DLC_OFF+CAN_DLC_W-1];
        data_d     = frame_q[CAN_DATA_OFF : CAN_DATA_OFF+CAN_DATA_W-1];
        crc_err_d  = crc_err_f;
        form_err_d = form_err_f;
        ack_d      = ~frame_q[CAN_ACK_POS];
        if (filt_hit) begin
          drop_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_dv_d = 1'b1;
          state_d    = ST_VALID;
        end
      end
      ST_VALID: begin
        if (i_Frame_Ready) begin
          frame_dv_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control state and all outputs; reset discards any frame in progress.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      frame_dv_q <= 1'b0;
      id_q       <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      crc_err_q  <= 1'b0;
      form_err_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_dv_q <= frame_dv_d;
      id_q       <= id_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      crc_err_q  <= crc_err_d;
      form_err_q <= form_err_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      drop_q     <= drop_d;
    end
  end

  // Frame shift register: pure data, only loaded when a frame is accepted.
  always_ff @(posedge i_Clock) begin
    frame_q <= frame_d;
  end

  assign o_Frame_DV = frame_dv_q;
  assign o_Id       = id_q;
  assign o_Rtr      = rtr_q;
  assign o_Dlc      = dlc_q;
  assign o_Data     = data_q;
  assign o_Crc_Err  = crc_err_q;
  assign o_Form_Err = form_err_q;
  assign o_Ack      = ack_q;
  assign o_Busy     = busy_q;
  assign o_Overrun  = overrun_q;
  assign o_Drop     = drop_q;

endmodule

// File: tb/tb_can_frame_check.sv
// Scoreboard bench for can_frame_check; honours CAN_FILTER_EN when defined.
module tb_can_frame_check;

  localparam logic [10:0] FID   = 11'h123;
  localparam logic [10:0] FMASK = 11'h7FF;

  typedef struct {
    int unsigned cyc;
    bit          drop;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        crc_err;
    logic        form_err;
    logic        ack;
  } exp_t;

  logic          i_Clock = 1'b0;
  logic          i_Rst_n = 1'b0;
  logic          i_Rx_DV = 1'b0;
  logic [0:107]  i_Rx_Frame = '0;
  logic          i_Frame_Ready = 1'b1;
  logic          o_Frame_DV, o_Rtr, o_Crc_Err, o_Form_Err, o_Ack, o_Busy, o_Overrun, o_Drop;
  logic [10:0]   o_Id;
  logic [3:0]    o_Dlc;
  logic [63:0]   o_Data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic        prev_dv = 1'b0;

  can_frame_check #(.FILT_ID(FID), .FILT_MASK(FMASK)) dut (
    .i_Clock       (i_Clock),
    .i_Rst_n       (i_Rst_n),
    .i_Rx_DV       (i_Rx_DV),
    .i_Rx_Frame    (i_Rx_Frame),
    .i_Frame_Ready (i_Frame_Ready),
    .o_Frame_DV    (o_Frame_DV),
    .o_Id          (o_Id),
    .o_Rtr         (o_Rtr),
    .o_Dlc         (o_Dlc),
    .o_Data        (o_Data),
    .o_Crc_Err     (o_Crc_Err),
    .o_Form_Err    (o_Form_Err),
    .o_Ack         (o_Ack),
    .o_Busy        (o_Busy),
    .o_Overrun     (o_Overrun),
    .o_Drop        (o_Drop)
  );

  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:107] build(input logic [10:0] id, input logic rtr,
                                         input logic [3:0] dlc, input logic [63:0] data,
                                         input logic ackb);
    logic [0:107] f;
    logic [14:0]  c;
    logic         fb;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 11; i++) f[1+i] = id[10-i];
    f[12] = rtr;
    f[13] = 1'b0;
    f[14] = 1'b0;
    for (int i = 0; i < 4; i++)  f[15+i] = dlc[3-i];
    for (int i = 0; i < 64; i++) f[19+i] = data[63-i];
    c = '0;
    for (int i = 0; i < 83; i++) begin
      fb = f[i] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    for (int i = 0; i < 15; i++) f[83+i] = c[14-i];
    f[98]  = 1'b1;
    f[99]  = ackb;
    f[100] = 1'b1;
    return f;
  endfunction

  function automatic exp_t mk_exp(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                                  input logic [63:0] data, input logic ackb,
                                  input logic cerr, input logic ferr);
    exp_t e;
    e.cyc      = 0;
    e.id       = id;
    e.rtr      = rtr;
    e.dlc      = dlc;
    e.data     = data;
    e.crc_err  = cerr;
    e.form_err = ferr;
    e.ack      = ~ackb;
`ifdef CAN_FILTER_EN
    e.drop = !cerr && !ferr && (((id ^ FID) & FMASK) != 11'h000);
`else
    e.drop = 1'b0;
`endif
    return e;
  endfunction

  // Called at a falling edge; output is due 85 edges on (sampling edge + 84).
  task automatic send(input logic [0:107] f, input exp_t e);
    e.cyc = cyc + 85;
    sb.push_back(e);
    i_Rx_Frame = f;
    i_Rx_DV    = 1'b1;
    @(negedge i_Clock);
    i_Rx_DV    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && o_Busy; k++) @(negedge i_Clock);
    chk("idle_wait", o_Busy, 1'b0);
    @(negedge i_Clock);
  endtask

  task automatic wait_dv();
    for (int k = 0; k < 200 && !o_Frame_DV; k++) @(negedge i_Clock);
    chk("dv_wait", o_Frame_DV, 1'b1);
  endtask

  // Scoreboard: pop and compare on each newly presented or dropped frame.
  always @(negedge i_Clock) begin
    if ((o_Frame_DV && !prev_dv) || o_Drop) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
        chk("drop", o_Drop, mon_e.drop);
        chk("dv_vs_drop", o_Frame_DV, !mon_e.drop);
        if (!mon_e.drop) begin
          chk("id", o_Id, mon_e.id);
          chk("rtr", o_Rtr, mon_e.rtr);
          chk("dlc", o_Dlc, mon_e.dlc);
          chk("data", o_Data, mon_e.data);
          chk("crc_err", o_Crc_Err, mon_e.crc_err);
          chk("form_err", o_Form_Err, mon_e.form_err);
          chk("ack", o_Ack, mon_e.ack);
        end
      end
    end
    prev_dv = o_Frame_DV;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:107] f;
    logic [10:0]  hid;
    logic [63:0]  hdata;
    logic [10:0]  rid;
    logic [63:0]  rdata;
    logic         rack;

    repeat (3) @(negedge i_Clock);
    chk("rst_ctl", {o_Frame_DV, o_Busy, o_Overrun, o_Drop, o_Crc_Err, o_Form_Err, o_Ack, o_Rtr}, 8'h00);
    chk("rst_fields", {o_Id, o_Dlc}, 15'h0);
    chk("rst_data", o_Data, 64'h0);

    // Frame strobed in the same cycle reset is released.
    i_Rst_n = 1'b1;
    f = build(11'h014, 1'b0, 4'h3, 64'h5555_5555_5555_5555, 1'b0);
    send(f, mk_exp(11'h014, 1'b0, 4'h3, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b0));
    chk("busy_after_dv", o_Busy, 1'b1);
    wait_idle();

    // CRC field corrupted.
    f = build(11'h014, 1'b0, 4'h3, 64'h5555_5555_5555_5555, 1'b0);
    f[90] = ~f[90];
    send(f, mk_exp(11'h014, 1'b0, 4'h3, 64'h5555_5555_5555_5555, 1'b0, 1'b1, 1'b0));
    wait_idle();

    // EOF bit cleared.
    f = build(11'h014, 1'b0, 4'h3, 64'h5555_5555_5555_5555, 1'b0);
    f[104] = 1'b0;
    send(f, mk_exp(11'h014, 1'b0, 4'h3, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b1));
    wait_idle();

    // Filter match, then raw DLC 15 with RTR and no ACK.
    f = build(11'h123, 1'b0, 4'h8, 64'hDEAD_BEEF_0123_4567, 1'b0);
    send(f, mk_exp(11'h123, 1'b0, 4'h8, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b0));
    wait_idle();
    f = build(11'h7FF, 1'b1, 4'hF, 64'hA5A5_0000_FFFF_1234, 1'b1);
    send(f, mk_exp(11'h7FF, 1'b1, 4'hF, 64'hA5A5_0000_FFFF_1234, 1'b1, 1'b0, 1'b0));
    wait_idle();

    // A few random frames.
    for (int n = 0; n < 4; n++) begin
      rid   = 11'($urandom_range(0, 2047));
      rdata = {$urandom, $urandom};
      rack  = 1'($urandom_range(0, 1));
      f = build(rid, 1'b0, 4'($urandom_range(0, 15)), rdata, rack);
      send(f, mk_exp(rid, 1'b0, {f[15], f[16], f[17], f[18]}, rdata, rack, 1'b0, 1'b0));
      wait_idle();
    end

    // Overrun mid-CRC, then a 10-clock stall with fields held.
    i_Frame_Ready = 1'b0;
    f = build(11'h123, 1'b0, 4'h2, 64'h0102_0304_0506_0708, 1'b0);
    send(f, mk_exp(11'h123, 1'b0, 4'h2, 64'h0102_0304_0506_0708, 1'b0, 1'b0, 1'b0));
    repeat (38) @(negedge i_Clock);
    i_Rx_Frame = build(11'h055, 1'b0, 4'h1, 64'h1, 1'b0);
    i_Rx_DV = 1'b1;
    @(negedge i_Clock);
    i_Rx_DV = 1'b0;
    chk("overrun_pulse", o_Overrun, 1'b1);
    @(negedge i_Clock);
    chk("overrun_clear", o_Overrun, 1'b0);
    wait_dv();
    hid   = o_Id;
    hdata = o_Data;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_Clock);
      chk("hold_dv", o_Frame_DV, 1'b1);
      chk("hold_fields", {o_Id, o_Data}, {hid, hdata});
    end
    // Handshake with a coincident strobe: strobe is lost.
    i_Frame_Ready = 1'b1;
    i_Rx_DV = 1'b1;
    @(negedge i_Clock);
    i_Rx_DV = 1'b0;
    chk("hs_dv_low", o_Frame_DV, 1'b0);
    chk("hs_overrun", o_Overrun, 1'b1);
    chk("hs_idle", o_Busy, 1'b0);
    repeat (100) @(negedge i_Clock);
    chk("hs_no_frame", o_Busy, 1'b0);

    // Reset 50 clocks into CRC, then a fresh frame.
    f = build(11'h2AA, 1'b0, 4'h4, 64'hCAFE_F00D_0000_0001, 1'b0);
    send(f, mk_exp(11'h2AA, 1'b0, 4'h4, 64'hCAFE_F00D_0000_0001, 1'b0, 1'b0, 1'b0));
    repeat (49) @(negedge i_Clock);
    chk("pre_rst_busy", o_Busy, 1'b1);
    #2 i_Rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {o_Frame_DV, o_Busy, o_Overrun, o_Drop, o_Crc_Err, o_Form_Err, o_Ack, o_Rtr}, 8'h00);
    chk("mid_rst_fields", {o_Id, o_Dlc}, 15'h0);
    chk("mid_rst_data", o_Data, 64'h0);
    sb.delete();
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    f = build(11'h0F0, 1'b0, 4'h6, 64'h1122_3344_5566_7788, 1'b0);
    send(f, mk_exp(11'h0F0, 1'b0, 4'h6, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0));
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
